spi_cfg_responder: RTL and testbench



---
 rtl/spi_cfg_responder_if.sv | 26 ++
 rtl/spi_cfg_responder.sv | 195 +++++++++++++++++++
 tb/tb_spi_cfg_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_responder_if.sv
// Bundles the SPI pins and the parallel configuration outputs of
// spi_cfg_responder. The master modport is the initiator/system side.
// The slave modport is the responder block.
interface spi_cfg_responder_if #(
    parameter int FRAME_BITS = 64
);
    logic                  spi_sel;
    logic                  cs_b;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic [FRAME_BITS-1:0] cfg_reg;
    logic                  cfg_valid;
    logic                  frame_err;
    logic                  busy;

    modport master (
        output spi_sel, cs_b, sclk, mosi,
        input  miso, cfg_reg, cfg_valid, frame_err, busy
    );

    modport slave (
        input  spi_sel, cs_b, sclk, mosi,
        output miso, cfg_reg, cfg_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_cfg_responder.sv
// spi_cfg_responder: SPI mode-0 target that runs fully on clk.
// - The SPI pins are oversampled through SYNC_STAGES flops and edge-detected.
// - FRAME_BITS-bit frames are shifted in MSB first.
// - A frame with exactly FRAME_BITS sclk rises is committed to cfg_reg.
//   Any other frame length pulses frame_err instead.
// Optional macro SPI_READBACK_EN:
// - When defined, miso shifts out the cfg_reg value captured at frame start.
// - When undefined, there is no transmit shifter and miso is tied to 0.
module spi_cfg_responder #(
    parameter int FRAME_BITS  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_cfg_responder_if.slave      bus
);
    localparam int CNT_W = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    // Synchronizer chains. Bit 0 of each *_chain is the raw pin.
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES:0]   w_cs_chain;
    logic [SYNC_STAGES:0]   w_sclk_chain;
    logic [SYNC_STAGES:0]   w_mosi_chain;
    logic                   r_cs_hist;
    logic                   r_sclk_hist;

    // The cs_b synchronizer resets high. If the pin is still low when reset
    // is released, it would look like a fresh fall. r_flush marks when the
    // chain holds real pin samples. r_armed then waits until cs_b has been
    // seen high before any fall is accepted.
    logic [SYNC_STAGES-1:0] r_flush;
    logic [SYNC_STAGES:0]   w_flush_chain;
    logic                   r_armed;

    logic w_cs_s, w_sclk_s, w_mosi_s;
    logic w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;

    state_t                r_state, w_state_next;
    logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_next;
    logic [FRAME_BITS-1:0] r_rx_sh, w_rx_sh_next;
    logic [FRAME_BITS-1:0] r_cfg_reg, w_cfg_reg_next;
    logic                  r_cfg_valid, w_cfg_valid_next;
    logic                  r_frame_err, w_frame_err_next;
    logic                  r_pend, w_pend_next;
`ifdef SPI_READBACK_EN
    logic [FRAME_BITS-1:0] r_tx_sh, w_tx_sh_next;
`endif

    assign w_cs_chain    = {r_cs_sync, bus.cs_b};
    assign w_sclk_chain  = {r_sclk_sync, bus.sclk};
    assign w_mosi_chain  = {r_mosi_sync, bus.mosi};
    assign w_flush_chain = {r_flush, 1'b1};

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    assign w_cs_fall   = r_armed & r_cs_hist & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_hist & w_cs_s;
    assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;

    // Input synchronizers, edge-history flops and the post-reset cs_b arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_hist   <= 1'b1;
            r_sclk_hist <= 1'b0;
            r_flush     <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_cs_sync   <= w_cs_chain[SYNC_STAGES-1:0];
            r_sclk_sync <= w_sclk_chain[SYNC_STAGES-1:0];
            r_mosi_sync <= w_mosi_chain[SYNC_STAGES-1:0];
            r_cs_hist   <= w_cs_s;
            r_sclk_hist <= w_sclk_s;
            r_flush     <= w_flush_chain[SYNC_STAGES-1:0];
            r_armed     <= r_armed | (r_flush[SYNC_STAGES-1] & w_cs_s);
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_rx_sh     <= '0;
            r_cfg_reg   <= '0;
            r_cfg_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_pend      <= 1'b0;
`ifdef SPI_READBACK_EN
            r_tx_sh     <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_rx_sh     <= w_rx_sh_next;
            r_cfg_reg   <= w_cfg_reg_next;
            r_cfg_valid <= w_cfg_valid_next;
            r_frame_err <= w_frame_err_next;
            r_pend      <= w_pend_next;
`ifdef SPI_READBACK_EN
            r_tx_sh     <= w_tx_sh_next;
`endif
        end
    end

    // Next-state and datapath logic. The commit/error pulses default low.
    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_rx_sh_next     = r_rx_sh;
        w_cfg_reg_next   = r_cfg_reg;
        w_cfg_valid_next = 1'b0;
        w_frame_err_next = 1'b0;
        w_pend_next      = r_pend;
`ifdef SPI_READBACK_EN
        w_tx_sh_next     = r_tx_sh;
`endif
        case (r_state)
            ST_IDLE: begin
                // r_pend covers a frame start seen during the COMMIT cycle.
                if (r_pend || (w_cs_fall && bus.spi_sel)) begin
                    w_state_next   = ST_SHIFT;
                    w_bit_cnt_next = '0;
                    w_rx_sh_next   = '0;
                    w_pend_next    = 1'b0;
`ifdef SPI_READBACK_EN
                    w_tx_sh_next   = r_cfg_reg;
`endif
                end
            end
            ST_SHIFT: begin
                // The end of the frame has priority over an sclk edge
                // detected in the same cycle.
                if (w_cs_rise) begin
                    w_state_next = ST_COMMIT;
                end else begin
                    if (w_sclk_rise) begin
                        w_rx_sh_next = {r_rx_sh[FRAME_BITS-2:0], w_mosi_s};
                        if (r_bit_cnt != CNT_W'(FRAME_BITS + 1)) begin
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end
`ifdef SPI_READBACK_EN
                    if (w_sclk_fall) begin
                        w_tx_sh_next = {r_tx_sh[FRAME_BITS-2:0], 1'b0};
                    end
`endif
                end
            end
            ST_COMMIT: begin
                w_state_next = ST_IDLE;
                if (r_bit_cnt == CNT_W'(FRAME_BITS)) begin
                    w_cfg_reg_next   = r_rx_sh;
                    w_cfg_valid_next = 1'b1;
                end else begin
                    w_frame_err_next = 1'b1;
                end
                if (w_cs_fall && bus.spi_sel) begin
                    w_pend_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef SPI_READBACK_EN
    assign bus.miso = (r_state == ST_SHIFT) ? r_tx_sh[FRAME_BITS-1] : 1'b0;
`else
    // Without the readback shifter, sclk falls have no effect on state.
    logic w_unused_sclk_fall;
    assign w_unused_sclk_fall = w_sclk_fall;
    assign bus.miso = 1'b0;
`endif

    assign bus.cfg_reg   = r_cfg_reg;
    assign bus.cfg_valid = r_cfg_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_spi_cfg_responder.sv
// Self-checking bench for spi_cfg_responder.
// - A table of frames is applied with their expected outcomes.
// - Expected commit/error events go into a scoreboard queue.
// - A monitor pops the queue as the DUT pulses cfg_valid/frame_err.
// - Hand-written sequences cover reset mid-frame and back-to-back frames.
module tb_spi_cfg_responder;
    localparam int FB        = 64;
    localparam int SYNC      = 2;
    localparam int SCLK_HALF = 5;
    localparam int LATENCY   = SYNC + 2;
`ifdef SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic clk;
    logic rst;

    spi_cfg_responder_if #(.FRAME_BITS(FB)) bus_if ();

    spi_cfg_responder #(.FRAME_BITS(FB), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          nbits;
        bit          sel;
        bit          drop_sel;
        bit          exp_valid;
        bit          exp_err;
        logic [63:0] exp_cfg;
        bit          exp_busy;
    } vec_t;

    typedef struct {
        bit          is_err;
        logic [63:0] cfg;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   busy_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (bus_if.busy) busy_seen = 1'b1;
        if (!bus_if.busy) check("miso_outside_shift", 64'(bus_if.miso), 64'd0);
        if (bus_if.cfg_valid || bus_if.frame_err) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: cfg_valid=%0b frame_err=%0b cfg_reg=0x%016h, expected no pulse",
                         bus_if.cfg_valid, bus_if.frame_err, bus_if.cfg_reg);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_cfg_valid", 64'(bus_if.cfg_valid), 64'(!e.is_err));
                check("pulse_frame_err", 64'(bus_if.frame_err), 64'(e.is_err));
                check("pulse_cfg_reg", bus_if.cfg_reg, e.cfg);
            end
        end
    end

    // One sclk period: mosi set while sclk is low, miso sampled at the rise.
    task automatic clock_bit(input logic b, output logic m);
        bus_if.mosi = b;
        repeat (SCLK_HALF) @(negedge clk);
        m = bus_if.miso;
        bus_if.sclk = 1'b1;
        repeat (SCLK_HALF) @(negedge clk);
        bus_if.sclk = 1'b0;
    endtask

    // Drives a whole frame and returns the first (up to 64) miso bits.
    // With short_gap set, cs_b is left high for one clk only.
    // The next call then starts a back-to-back frame.
    task automatic send_frame(input logic [63:0] data, input int nbits, input bit sel,
                              input bit drop_sel, input bit short_gap, input bit exp_pulse,
                              output logic [63:0] rd);
        logic m;
        int   n;
        @(negedge clk);
        bus_if.spi_sel = sel;
        bus_if.sclk    = 1'b0;
        bus_if.cs_b    = 1'b0;
        rd = '0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            clock_bit((i < 64) ? data[63 - i] : 1'b1, m);
            if (i < 64) rd = {rd[62:0], m};
            if (drop_sel && i == 20) bus_if.spi_sel = 1'b0;
        end
        repeat (SCLK_HALF) @(negedge clk);
        bus_if.cs_b = 1'b1;
        if (!short_gap) begin
            if (exp_pulse) begin
                n = 0;
                while (n < 12) begin
                    @(negedge clk);
                    n++;
                    if (bus_if.cfg_valid || bus_if.frame_err) break;
                end
                check("pulse_latency", 64'(n), 64'(LATENCY));
            end
            repeat (10) @(negedge clk);
        end
    endtask

    vec_t        vecs[7];
    logic [63:0] model_cfg;
    logic [63:0] exp_rd;
    logic [63:0] rd;
    logic [63:0] rd_a;
    logic        m;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'hDEADBEEF_01234567, 64, 1'b1, 1'b0, 1'b1, 1'b0, 64'hDEADBEEF_01234567, 1'b1};
        vecs[1] = '{64'h0F0F0F0F_F0F0F0F0, 64, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0F0F0F0F_F0F0F0F0, 1'b1};
        vecs[2] = '{64'hAAAAAAAA_AAAAAAAA, 40, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0F0F0F0F_F0F0F0F0, 1'b1};
        vecs[3] = '{64'h55555555_55555555, 65, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0F0F0F0F_F0F0F0F0, 1'b1};
        vecs[4] = '{64'h12345678_9ABCDEF0, 64, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0F0F0F0F_F0F0F0F0, 1'b0};
        vecs[5] = '{64'h12345678_9ABCDEF0, 64, 1'b1, 1'b0, 1'b1, 1'b0, 64'h12345678_9ABCDEF0, 1'b1};
        vecs[6] = '{64'hCAFEF00D_8BADF00D, 64, 1'b1, 1'b1, 1'b1, 1'b0, 64'hCAFEF00D_8BADF00D, 1'b1};

        rst = 1'b1;
        bus_if.spi_sel = 1'b0;
        bus_if.cs_b    = 1'b1;
        bus_if.sclk    = 1'b0;
        bus_if.mosi    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cfg_reg", bus_if.cfg_reg, 64'd0);
        check("reset_cfg_valid", 64'(bus_if.cfg_valid), 64'd0);
        check("reset_frame_err", 64'(bus_if.frame_err), 64'd0);
        check("reset_busy", 64'(bus_if.busy), 64'd0);
        check("reset_miso", 64'(bus_if.miso), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        model_cfg = 64'd0;

        for (int v = 0; v < 7; v++) begin
            exp_rd = READBACK ? model_cfg : 64'd0;
            if (vecs[v].nbits < 64) exp_rd = exp_rd >> (64 - vecs[v].nbits);
            if (!vecs[v].sel) exp_rd = 64'd0;
            if (vecs[v].exp_valid || vecs[v].exp_err)
                exp_q.push_back('{vecs[v].exp_err, vecs[v].exp_cfg});
            busy_seen = 1'b0;
            send_frame(vecs[v].data, vecs[v].nbits, vecs[v].sel, vecs[v].drop_sel, 1'b0,
                       vecs[v].exp_valid | vecs[v].exp_err, rd);
            check($sformatf("v%0d_readback", v), rd, exp_rd);
            check($sformatf("v%0d_cfg_reg", v), bus_if.cfg_reg, vecs[v].exp_cfg);
            check($sformatf("v%0d_busy_seen", v), 64'(busy_seen), 64'(vecs[v].exp_busy));
            check($sformatf("v%0d_scoreboard_empty", v), 64'(exp_q.size()), 64'd0);
            model_cfg = vecs[v].exp_cfg;
        end

        // Reset at bit 30. The rest of the frame is clocked with cs_b still
        // low and must not produce a commit.
        @(negedge clk);
        bus_if.spi_sel = 1'b1;
        bus_if.cs_b    = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 30; i++) clock_bit(1'b1, m);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_cfg_reg", bus_if.cfg_reg, 64'd0);
        check("midrst_busy", 64'(bus_if.busy), 64'd0);
        rst = 1'b0;
        for (int i = 30; i < 64; i++) clock_bit(1'b1, m);
        repeat (SCLK_HALF) @(negedge clk);
        bus_if.cs_b = 1'b1;
        repeat (12) @(negedge clk);
        check("after_rst_cfg_reg", bus_if.cfg_reg, 64'd0);
        check("after_rst_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        exp_q.push_back('{1'b0, 64'h1});
        send_frame(64'h1, 64, 1'b1, 1'b0, 1'b0, 1'b1, rd);
        check("post_rst_readback", rd, 64'd0);
        check("post_rst_cfg_reg", bus_if.cfg_reg, 64'h1);
        check("post_rst_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Back-to-back frames. cs_b is high for one clk, so the next fall
        // lands in the COMMIT cycle.
        exp_q.push_back('{1'b0, 64'hA5A5A5A5_5A5A5A5A});
        exp_q.push_back('{1'b0, 64'h13579BDF_2468ACE0});
        send_frame(64'hA5A5A5A5_5A5A5A5A, 64, 1'b1, 1'b0, 1'b1, 1'b0, rd_a);
        send_frame(64'h13579BDF_2468ACE0, 64, 1'b1, 1'b0, 1'b0, 1'b1, rd);
        check("b2b_first_readback", rd_a, READBACK ? 64'h1 : 64'd0);
        check("b2b_second_readback", rd, READBACK ? 64'hA5A5A5A5_5A5A5A5A : 64'd0);
        check("b2b_cfg_reg", bus_if.cfg_reg, 64'h13579BDF_2468ACE0);
        check("b2b_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
